// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA framebuffer controller.
// Latency: none (package only).
// Backpressure: none (package only).
package vga_pkg;

  // One raster axis: displayed, front porch, sync, back porch
  typedef struct packed {
    int disp;
    int front;
    int sync;
    int back;
  } vga_axis_t;

  localparam vga_axis_t H_DEFAULT = '{disp: 1280, front: 48, sync: 112, back: 248};
  localparam vga_axis_t V_DEFAULT = '{disp: 1024, front: 1,  sync: 3,   back: 38};

  // Palette entries with a non-black colour out of reset
  localparam int PAL_WHITE = 1;
  localparam int PAL_BLUE  = 2;
  localparam int PAL_GREEN = 3;

  typedef enum logic {
    CLR_IDLE,
    CLR_CLEAR
  } clr_state_e;

  // Raster flags carried alongside the pixel read pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } pipe_flags_t;

  function automatic int hmax(input int hd, input int hf, input int hr, input int hb);
    return hd + hf + hr + hb - 1;
  endfunction

  function automatic int vmax(input int vd, input int vf, input int vr, input int vb);
    return vd + vf + vr + vb - 1;
  endfunction

  // Reset colour of a palette entry; blue occupies the top channel, green the middle
  function automatic logic [31:0] pal_reset(input int idx, input int rgb_bits);
    int cw;
    logic [31:0] chan;
    cw   = rgb_bits / 3;
    chan = (32'd1 << cw) - 32'd1;
    case (idx)
      PAL_WHITE: return (rgb_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rgb_bits) - 32'd1);
      PAL_BLUE:  return chan << (2 * cw);
      PAL_GREEN: return chan << cw;
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: h/v counters plus unregistered sync, active and frame-start flags.
// Latency: flags are combinational from the counters (0 cycles).
// Backpressure: none; free-running every pixel clock.
module vga_timing import vga_pkg::*; #(
  parameter int HD = 1280,
  parameter int HF = 48,
  parameter int HR = 112,
  parameter int HB = 248,
  parameter int VD = 1024,
  parameter int VF = 1,
  parameter int VR = 3,
  parameter int VB = 38,
  localparam int HW = $clog2(hmax(HD, HF, HR, HB) + 1),
  localparam int VW = $clog2(vmax(VD, VF, VR, VB) + 1)
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_act,
  output logic          vsync_act,
  output logic          active,
  output logic          frame_first
);

  localparam int HMAX = hmax(HD, HF, HR, HB);
  localparam int VMAX = vmax(VD, VF, VR, VB);

  // Pixel counter wraps at end of line and advances the line counter
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == HW'(HMAX)) begin
      hcount <= '0;
      vcount <= (vcount == VW'(VMAX)) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  assign hsync_act   = (hcount >= HW'(HD + HF)) && (hcount <= HW'(HD + HF + HR - 1));
  assign vsync_act   = (vcount >= VW'(VD + VF)) && (vcount <= VW'(VD + VF + VR - 1));
  assign active      = (hcount < HW'(HD)) && (vcount < VW'(VD));
  assign frame_first = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_fb_ctrl.sv
// Indexed-colour VGA framebuffer with writable palette; optional clear engine (VGA_FB_CLEAR_EN).
// Latency: 3 cycles from raster position to rgb_o/syncs; a write shows if accepted 2 cycles before its read address.
// Backpressure: wr_ready_o is high except while a screen clear runs; out-of-range writes are acked and dropped.
module vga_fb_ctrl import vga_pkg::*; #(
  parameter int   HD       = H_DEFAULT.disp,
  parameter int   HF       = H_DEFAULT.front,
  parameter int   HR       = H_DEFAULT.sync,
  parameter int   HB       = H_DEFAULT.back,
  parameter int   VD       = V_DEFAULT.disp,
  parameter int   VF       = V_DEFAULT.front,
  parameter int   VR       = V_DEFAULT.sync,
  parameter int   VB       = V_DEFAULT.back,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   PIX_BITS = 2,
  parameter int   RGB_BITS = 12
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [10:0]         wr_x_i,
  input  logic [10:0]         wr_y_i,
  input  logic [PIX_BITS-1:0] wr_idx_i,
  input  logic                pal_we_i,
  input  logic [PIX_BITS-1:0] pal_addr_i,
  input  logic [RGB_BITS-1:0] pal_data_i,
  input  logic                clear_i,
  input  logic [PIX_BITS-1:0] clear_idx_i,
  output logic                clear_busy_o,
  output logic                vga_hs_o,
  output logic                vga_vs_o,
  output logic [RGB_BITS-1:0] rgb_o,
  output logic                frame_start_o
);

  localparam int HW    = $clog2(hmax(HD, HF, HR, HB) + 1);
  localparam int VW    = $clog2(vmax(VD, VF, VR, VB) + 1);
  localparam int DEPTH = HD * VD;
  localparam int AW    = $clog2(DEPTH);
  localparam int NPAL  = 2 ** PIX_BITS;

  logic [HW-1:0]       hcount;
  logic [VW-1:0]       vcount;
  pipe_flags_t         raw_flags, s1_flags, s2_flags;
  logic [AW-1:0]       addr_q;
  logic [PIX_BITS-1:0] rd_idx;
  logic [PIX_BITS-1:0] fb_mem [DEPTH];
  logic [RGB_BITS-1:0] pal [NPAL];
  logic                wr_in_range;
  logic [AW-1:0]       wr_addr;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [PIX_BITS-1:0] mem_wdat;

  vga_timing #(
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB)
  ) u_timing (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync_act   (raw_flags.hs),
    .vsync_act   (raw_flags.vs),
    .active      (raw_flags.act),
    .frame_first (raw_flags.fs)
  );

  assign wr_in_range = (int'(wr_x_i) < HD) && (int'(wr_y_i) < VD);
  assign wr_addr     = AW'(int'(wr_y_i) * HD + int'(wr_x_i));

`ifdef VGA_FB_CLEAR_EN
  clr_state_e          clr_state, clr_state_nxt;
  logic [AW-1:0]       clr_addr;
  logic [PIX_BITS-1:0] clr_idx;

  // Clear FSM state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) clr_state <= CLR_IDLE;
    else          clr_state <= clr_state_nxt;
  end

  // Start on clear_i from idle; finish after the last framebuffer address
  always_comb begin
    clr_state_nxt = clr_state;
    case (clr_state)
      CLR_IDLE:  if (clear_i) clr_state_nxt = CLR_CLEAR;
      CLR_CLEAR: if (clr_addr == AW'(DEPTH - 1)) clr_state_nxt = CLR_IDLE;
      default:   clr_state_nxt = CLR_IDLE;
    endcase
  end

  // Sweep address and fill index latched at the start of the clear
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      clr_addr <= '0;
      clr_idx  <= '0;
    end else if (clr_state == CLR_IDLE) begin
      clr_addr <= '0;
      if (clear_i) clr_idx <= clear_idx_i;
    end else begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  assign clear_busy_o = (clr_state == CLR_CLEAR);
`else
  logic unused_clear;
  assign unused_clear = ^{clear_i, clear_idx_i};
  assign clear_busy_o = 1'b0;
`endif

  assign wr_ready_o = ~clear_busy_o;

  // Single framebuffer write port: clear sweep owns it while busy
  always_comb begin
    mem_we    = wr_valid_i && wr_ready_o && wr_in_range;
    mem_waddr = wr_addr;
    mem_wdat  = wr_idx_i;
`ifdef VGA_FB_CLEAR_EN
    if (clear_busy_o) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdat  = clr_idx;
    end
`endif
  end

  // Framebuffer write
  always_ff @(posedge clk_i) begin
    if (mem_we) fb_mem[mem_waddr] <= mem_wdat;
  end

  // Framebuffer read; a same-cycle write to this address is seen next time
  always_ff @(posedge clk_i) begin
    rd_idx <= fb_mem[addr_q];
  end

  // Palette: reset colours, then overwritten by the host strobe
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < NPAL; i++) pal[i] <= RGB_BITS'(pal_reset(i, RGB_BITS));
    end else if (pal_we_i) begin
      pal[pal_addr_i] <= pal_data_i;
    end
  end

  // Stages 1-2: register read address, carry raster flags alongside
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      addr_q   <= '0;
      s1_flags <= '0;
      s2_flags <= '0;
    end else begin
      addr_q   <= raw_flags.act ? AW'(int'(vcount) * HD + int'(hcount)) : '0;
      s1_flags <= raw_flags;
      s2_flags <= s1_flags;
    end
  end

  // Stage 3: palette lookup, blanking and sync polarity
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rgb_o         <= '0;
      vga_hs_o      <= ~HS_POL;
      vga_vs_o      <= ~VS_POL;
      frame_start_o <= 1'b0;
    end else begin
      rgb_o         <= s2_flags.act ? pal[rd_idx] : '0;
      vga_hs_o      <= s2_flags.hs ? HS_POL : ~HS_POL;
      vga_vs_o      <= s2_flags.vs ? VS_POL : ~VS_POL;
      frame_start_o <= s2_flags.fs;
    end
  end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl at an 8x4 raster (line 14 cycles, frame 98).
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: wr_ready_o checked on every write; clear busy window measured when VGA_FB_CLEAR_EN is set.
module tb_vga_fb_ctrl;

  localparam int LINE  = 14;
  localparam int FRAME = 98;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [10:0] wr_x_i = '0;
  logic [10:0] wr_y_i = '0;
  logic [1:0]  wr_idx_i = '0;
  logic        pal_we_i = 1'b0;
  logic [1:0]  pal_addr_i = '0;
  logic [11:0] pal_data_i = '0;
  logic        clear_i = 1'b0;
  logic [1:0]  clear_idx_i = '0;
  logic        clear_busy_o;
  logic        vga_hs_o;
  logic        vga_vs_o;
  logic [11:0] rgb_o;
  logic        frame_start_o;

  vga_fb_ctrl #(
    .HD(8), .HF(2), .HR(2), .HB(2),
    .VD(4), .VF(1), .VR(1), .VB(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .PIX_BITS(2), .RGB_BITS(12)
  ) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_x_i       (wr_x_i),
    .wr_y_i       (wr_y_i),
    .wr_idx_i     (wr_idx_i),
    .pal_we_i     (pal_we_i),
    .pal_addr_i   (pal_addr_i),
    .pal_data_i   (pal_data_i),
    .clear_i      (clear_i),
    .clear_idx_i  (clear_idx_i),
    .clear_busy_o (clear_busy_o),
    .vga_hs_o     (vga_hs_o),
    .vga_vs_o     (vga_vs_o),
    .rgb_o        (rgb_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] idx;
    logic [11:0] exp_rgb;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [1:0]  mfb [32];
  logic [11:0] mpal [4];
  logic [11:0] cap_rgb [FRAME];
  logic [11:0] prev_rgb [FRAME];
  logic        cap_hs [FRAME];
  logic        cap_vs [FRAME];
  logic        cap_fs [FRAME];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wr_px(input int x, input int y, input logic [1:0] idx);
    @(posedge clk_i); #1;
    wr_valid_i = 1'b1;
    wr_x_i     = 11'(x);
    wr_y_i     = 11'(y);
    wr_idx_i   = idx;
    @(negedge clk_i);
    chk($sformatf("wr_ready(%0d,%0d)", x, y), int'(wr_ready_o), 1);
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0;
    if (x < 8 && y < 4) mfb[y*8 + x] = idx;
  endtask

  task automatic capture();
    int guard;
    guard = 0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    while (!frame_start_o && guard < 300) begin
      @(negedge clk_i);
      guard++;
    end
    if (!frame_start_o) begin
      chk("frame_start_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < FRAME; k++) begin
      cap_rgb[k] = rgb_o;
      cap_hs[k]  = vga_hs_o;
      cap_vs[k]  = vga_vs_o;
      cap_fs[k]  = frame_start_o;
      @(negedge clk_i);
    end
  endtask

  task automatic check_frame(input string nm);
    int e_rgb, e_hs, e_vs, e_fs, h, v;
    logic [11:0] er;
    e_rgb = 0; e_hs = 0; e_vs = 0; e_fs = 0;
    for (int k = 0; k < FRAME; k++) begin
      h  = k % LINE;
      v  = k / LINE;
      er = (h < 8 && v < 4) ? mpal[mfb[v*8 + h]] : 12'h000;
      if (cap_rgb[k] !== er) e_rgb++;
      if (cap_hs[k] !== (h >= 10 && h <= 11)) e_hs++;
      if (cap_vs[k] !== (v == 5)) e_vs++;
      if (cap_fs[k] !== (k == 0)) e_fs++;
    end
    chk({nm, "_rgb_errs"}, e_rgb, 0);
    chk({nm, "_hs_errs"},  e_hs,  0);
    chk({nm, "_vs_errs"},  e_vs,  0);
    chk({nm, "_fs_errs"},  e_fs,  0);
  endtask

  initial begin
    vec_t vecs [8];
    int   first_hs, second_hs, first_fs, diffs;
    logic prev_hs;

    vecs[0] = '{3, 2, 2'd1, 12'hFFF};
    vecs[1] = '{0, 0, 2'd2, 12'hF00};
    vecs[2] = '{7, 3, 2'd3, 12'h0F0};
    vecs[3] = '{7, 0, 2'd1, 12'hFFF};
    vecs[4] = '{0, 3, 2'd2, 12'hF00};
    vecs[5] = '{5, 1, 2'd3, 12'h0F0};
    vecs[6] = '{2, 2, 2'd0, 12'h000};
    vecs[7] = '{4, 2, 2'd0, 12'h000};

    mpal[0] = 12'h000; mpal[1] = 12'hFFF; mpal[2] = 12'hF00; mpal[3] = 12'h0F0;
    for (int i = 0; i < 32; i++) mfb[i] = 2'd0;

    // Reset and release
    repeat (3) @(posedge clk_i);
    #1 arstn_i = 1'b1;
    @(negedge clk_i);
    chk("rst_hs", int'(vga_hs_o), 0);
    chk("rst_vs", int'(vga_vs_o), 0);
    chk("rst_rgb", int'(rgb_o), 0);
    chk("rst_fs", int'(frame_start_o), 0);
    chk("rst_busy", int'(clear_busy_o), 0);
    chk("rst_ready", int'(wr_ready_o), 1);

    // Sync and frame-start timing measured in clocks since release
    first_hs = -1; second_hs = -1; first_fs = -1; prev_hs = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (vga_hs_o && !prev_hs) begin
        if (first_hs < 0) first_hs = n;
        else if (second_hs < 0) second_hs = n;
      end
      if (frame_start_o && first_fs < 0) first_fs = n;
      prev_hs = vga_hs_o;
    end
    chk("hs_first_rise", first_hs, 13);
    chk("hs_second_rise", second_hs, 27);
    chk("fs_first", first_fs, 3);

    // Known framebuffer contents
    for (int i = 0; i < 32; i++) wr_px(i % 8, i / 8, 2'd0);

    // Table of writes and their expected colour with the reset palette
    for (int i = 0; i < 8; i++) wr_px(vecs[i].x, vecs[i].y, vecs[i].idx);
    capture();
    for (int i = 0; i < 8; i++)
      chk($sformatf("vec%0d_rgb(%0d,%0d)", i, vecs[i].x, vecs[i].y),
          int'(cap_rgb[vecs[i].y*LINE + vecs[i].x]), int'(vecs[i].exp_rgb));
    check_frame("table");

    // Out-of-range writes are acknowledged and change nothing
    for (int k = 0; k < FRAME; k++) prev_rgb[k] = cap_rgb[k];
    wr_px(8, 0, 2'd3);
    wr_px(0, 4, 2'd3);
    capture();
    diffs = 0;
    for (int k = 0; k < FRAME; k++) if (cap_rgb[k] !== prev_rgb[k]) diffs++;
    chk("oob_frame_diffs", diffs, 0);

    // Palette rewrite of entry 1
    @(posedge clk_i); #1;
    pal_we_i = 1'b1; pal_addr_i = 2'd1; pal_data_i = 12'h0F0;
    @(posedge clk_i); #1;
    pal_we_i = 1'b0;
    mpal[1] = 12'h0F0;
    capture();
    chk("pal_px(3,2)", int'(cap_rgb[2*LINE + 3]), 12'h0F0);
    chk("pal_px(7,0)", int'(cap_rgb[7]), 12'h0F0);
    check_frame("palette");

`ifdef VGA_FB_CLEAR_EN
    begin
      int busy_cnt, rdy_bad;
      busy_cnt = 0; rdy_bad = 0;
      @(posedge clk_i); #1;
      clear_i = 1'b1; clear_idx_i = 2'd2;
      wr_valid_i = 1'b1; wr_x_i = 11'd1; wr_y_i = 11'd1; wr_idx_i = 2'd3;
      @(posedge clk_i); #1;
      clear_i = 1'b0; wr_valid_i = 1'b0;
      @(negedge clk_i);
      chk("clear_busy_start", int'(clear_busy_o), 1);
      for (int i = 0; i < 100; i++) begin
        if (clear_busy_o) begin
          busy_cnt++;
          if (wr_ready_o) rdy_bad++;
        end else if (busy_cnt > 0) begin
          break;
        end
        @(negedge clk_i);
      end
      chk("clear_busy_cycles", busy_cnt, 32);
      chk("clear_ready_high_while_busy", rdy_bad, 0);
      chk("clear_ready_after", int'(wr_ready_o), 1);
      for (int i = 0; i < 32; i++) mfb[i] = 2'd2;
      capture();
      chk("clear_px(1,1)", int'(cap_rgb[LINE + 1]), 12'hF00);
      check_frame("clear");

      // Start another clear and reset while it runs
      @(posedge clk_i); #1;
      clear_i = 1'b1; clear_idx_i = 2'd1;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      repeat (9) @(posedge clk_i);
    end
`else
    begin
      int busy_seen, rdy_low;
      busy_seen = 0; rdy_low = 0;
      @(posedge clk_i); #1;
      clear_i = 1'b1; clear_idx_i = 2'd2;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        if (clear_busy_o) busy_seen++;
        if (!wr_ready_o) rdy_low++;
      end
      chk("noclear_busy_cycles", busy_seen, 0);
      chk("noclear_ready_low_cycles", rdy_low, 0);
      capture();
      check_frame("noclear");
      repeat (9) @(posedge clk_i);
    end
`endif

    // Asynchronous reset while hsync is asserted
    begin
      int guard;
      guard = 0;
      @(posedge clk_i); #1;
      while (!vga_hs_o && guard < 30) begin
        @(posedge clk_i); #1;
        guard++;
      end
      chk("hs_before_midreset", int'(vga_hs_o), 1);
`ifdef VGA_FB_CLEAR_EN
      chk("busy_before_midreset", int'(clear_busy_o), 1);
`endif
      arstn_i = 1'b0;
      #1;
      chk("midrst_busy", int'(clear_busy_o), 0);
      chk("midrst_hs", int'(vga_hs_o), 0);
      chk("midrst_vs", int'(vga_vs_o), 0);
      chk("midrst_rgb", int'(rgb_o), 0);
      chk("midrst_fs", int'(frame_start_o), 0);
      chk("midrst_ready", int'(wr_ready_o), 1);
      repeat (2) @(posedge clk_i);
      #1 arstn_i = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
